// File: rtl/line_drawer_pkg.sv
// Shared types and sizing helpers for the Bresenham line drawer.
package line_drawer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2
  } state_t;

  // One bit for the sign and one of headroom so that 2*err never wraps.
  function automatic int err_width(input int x_w, input int y_w);
    return ((x_w > y_w) ? x_w : y_w) + 2;
  endfunction

endpackage

// File: rtl/line_drawer.sv
// Bresenham line drawer streaming one pixel per cycle to a framebuffer.
// Optional clipping of off-screen points is enabled by LINE_DRAWER_CLIP_EN.
module line_drawer
  import line_drawer_pkg::*;
#(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  localparam int X_WIDTH = $clog2(HOR_ACTIVE_PIXELS),
  localparam int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               ready,
  input  logic [X_WIDTH-1:0] x1,
  input  logic [Y_WIDTH-1:0] y1,
  input  logic [X_WIDTH-1:0] x2,
  input  logic [Y_WIDTH-1:0] y2,
  output logic [X_WIDTH-1:0] pixel_x,
  output logic [Y_WIDTH-1:0] pixel_y,
  output logic               pixel_valid,
  input  logic               pixel_ready
);

  localparam int EW = err_width(X_WIDTH, Y_WIDTH);

  state_t state, state_next;

  logic [X_WIDTH-1:0] x_beg, x_end, cur_x, cur_x_next, dx_abs;
  logic [Y_WIDTH-1:0] y_beg, y_end, cur_y, cur_y_next, dy_abs;
  logic signed [EW-1:0] dx, dy, err, err_next, dx_add, dy_add;
  logic signed [EW:0]   e2;
  logic sx_neg, sy_neg;
  logic step_x, step_y, at_end, clip, advance;

  always_comb begin
    dx_abs = (x_beg < x_end) ? (x_end - x_beg) : (x_beg - x_end);
    dy_abs = (y_beg < y_end) ? (y_end - y_beg) : (y_beg - y_end);
  end

`ifdef LINE_DRAWER_CLIP_EN
  localparam logic [X_WIDTH:0] HOR_LIM = (X_WIDTH + 1)'(HOR_ACTIVE_PIXELS);
  localparam logic [Y_WIDTH:0] VER_LIM = (Y_WIDTH + 1)'(VER_ACTIVE_PIXELS);
  assign clip = ({1'b0, cur_x} >= HOR_LIM) || ({1'b0, cur_y} >= VER_LIM);
`else
  assign clip = 1'b0;
`endif

  always_comb begin
    e2       = {err, 1'b0};
    step_x   = e2 >= (EW + 1)'(dy);
    step_y   = e2 <= (EW + 1)'(dx);
    dy_add   = step_x ? dy : '0;
    dx_add   = step_y ? dx : '0;
    err_next = err + dy_add + dx_add;
    cur_x_next = cur_x;
    if (step_x) cur_x_next = sx_neg ? cur_x - X_WIDTH'(1) : cur_x + X_WIDTH'(1);
    cur_y_next = cur_y;
    if (step_y) cur_y_next = sy_neg ? cur_y - Y_WIDTH'(1) : cur_y + Y_WIDTH'(1);
    at_end  = (cur_x == x_end) && (cur_y == y_end);
    // Clipped points retire on their own; visible ones wait for the framebuffer.
    advance = (state == DRAW) && (clip || pixel_ready);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SETUP;
      SETUP:   state_next = DRAW;
      DRAW:    if (advance && at_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_beg  <= '0;
      y_beg  <= '0;
      x_end  <= '0;
      y_end  <= '0;
      cur_x  <= '0;
      cur_y  <= '0;
      dx     <= '0;
      dy     <= '0;
      err    <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          x_beg <= x1;
          y_beg <= y1;
          x_end <= x2;
          y_end <= y2;
        end
        SETUP: begin
          dx     <= $signed(EW'(dx_abs));
          dy     <= -$signed(EW'(dy_abs));
          err    <= $signed(EW'(dx_abs)) - $signed(EW'(dy_abs));
          sx_neg <= !(x_beg < x_end);
          sy_neg <= !(y_beg < y_end);
          cur_x  <= x_beg;
          cur_y  <= y_beg;
        end
        DRAW: if (advance && !at_end) begin
          err   <= err_next;
          cur_x <= cur_x_next;
          cur_y <= cur_y_next;
        end
        default: ;
      endcase
    end
  end

  assign ready       = (state == IDLE);
  assign pixel_valid = (state == DRAW) && !clip;
  assign pixel_x     = cur_x;
  assign pixel_y     = cur_y;

endmodule
